// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter (M0 = CPU, M1 = DMA) with a one-deep address buffer per master,
// so a master that saw HREADY=1 for an address the bus did not take is still served.
module ahbl_master_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    logic [1:0][31:0] m_haddr, m_hwdata, pend_addr, eff_addr;
    logic [1:0][2:0]  m_hsize, pend_size, eff_size;
    logic [1:0][1:0]  m_htrans;
    logic [1:0]       m_hwrite, pend_write, eff_write;
    logic [1:0]       pend_v, req, m_hready;

    logic gnt, gnt_q, prio, dvalid, downer, hready_q, bus_nonseq;

    assign m_haddr  = {M1_HADDR, M0_HADDR};
    assign m_hwdata = {M1_HWDATA, M0_HWDATA};
    assign m_hsize  = {M1_HSIZE, M0_HSIZE};
    assign m_htrans = {M1_HTRANS, M0_HTRANS};
    assign m_hwrite = {M1_HWRITE, M0_HWRITE};

    for (genvar i = 0; i < 2; i++) begin : g_m
        localparam logic IDX = 1'(i);
        logic own;
        assign own         = dvalid && (downer == IDX);
        assign req[i]      = pend_v[i] | m_htrans[i][1];
        assign eff_addr[i] = pend_v[i] ? pend_addr[i]  : m_haddr[i];
        assign eff_size[i] = pend_v[i] ? pend_size[i]  : m_hsize[i];
        assign eff_write[i] = pend_v[i] ? pend_write[i] : m_hwrite[i];

        always_comb begin
            m_hready[i] = 1'b1;
            if (pend_v[i] && !own)  m_hready[i] = 1'b0;
            else if (own)           m_hready[i] = HREADY;
            else if (gnt == IDX)    m_hready[i] = HREADY;
            else if (m_htrans[i][1]) m_hready[i] = 1'b0;
        end
    end

    // Re-arbitrate only when the previous address phase completed; otherwise hold the bus steady.
    always_comb begin
        gnt = gnt_q;
        if (hready_q) begin
            if (req == 2'b11)  gnt = prio;
            else if (req[0])   gnt = 1'b0;
            else if (req[1])   gnt = 1'b1;
        end
    end

    assign bus_nonseq = req[gnt];
    assign HTRANS     = bus_nonseq ? TR_NONSEQ : TR_IDLE;
    assign HADDR      = eff_addr[gnt];
    assign HSIZE      = eff_size[gnt];
    assign HWRITE     = eff_write[gnt];
    assign HWDATA     = dvalid ? m_hwdata[downer] : 32'h0;
    assign M0_HREADY  = m_hready[0];
    assign M1_HREADY  = m_hready[1];
    assign M0_HRDATA  = HRDATA;
    assign M1_HRDATA  = HRDATA;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            gnt_q    <= 1'b0;
            prio     <= 1'b0;
            dvalid   <= 1'b0;
            downer   <= 1'b0;
            hready_q <= 1'b1;
            pend_v   <= 2'b00;
        end else begin
            hready_q <= HREADY;
            gnt_q    <= gnt;
            if (HREADY) begin
                dvalid <= bus_nonseq;
                downer <= gnt;
                if (ROUND_ROBIN && bus_nonseq) prio <= ~gnt;
            end
            // A master finishing its data phase while losing arbitration has already seen
            // HREADY=1 for its next address, so that address must be kept here.
            for (int i = 0; i < 2; i++) begin
                if (HREADY && gnt == 1'(i)) begin
                    pend_v[i] <= 1'b0;
                end else if (HREADY && dvalid && downer == 1'(i) && m_htrans[i][1] && !pend_v[i]) begin
                    pend_v[i]     <= 1'b1;
                    pend_addr[i]  <= m_haddr[i];
                    pend_size[i]  <= m_hsize[i];
                    pend_write[i] <= m_hwrite[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for ahbl_master_arbiter: a cycle table for the round-robin instance plus
// hand-written stall and fixed-priority sequences.
module tb_ahbl_master_arbiter;
    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic [31:0] M0_HADDR = '0, M1_HADDR = '0, M0_HWDATA = '0, M1_HWDATA = '0, HRDATA = '0;
    logic [1:0]  M0_HTRANS = '0, M1_HTRANS = '0;
    logic [2:0]  M0_HSIZE = 3'd2, M1_HSIZE = 3'd0;
    logic        M0_HWRITE = 1'b0, M1_HWRITE = 1'b0, HREADY = 1'b1;

    logic        M0_HREADY, M1_HREADY, HWRITE;
    logic [31:0] M0_HRDATA, M1_HRDATA, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    logic        fp_M0_HREADY, fp_M1_HREADY, fp_HWRITE;
    logic [31:0] fp_M0_HRDATA, fp_M1_HRDATA, fp_HADDR, fp_HWDATA;
    logic [1:0]  fp_HTRANS;
    logic [2:0]  fp_HSIZE;

    always #5 HCLK = ~HCLK;

    ahbl_master_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
        .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
        .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA)
    );

    ahbl_master_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
        .M0_HWDATA(M0_HWDATA), .M0_HREADY(fp_M0_HREADY), .M0_HRDATA(fp_M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
        .M1_HWDATA(M1_HWDATA), .M1_HREADY(fp_M1_HREADY), .M1_HRDATA(fp_M1_HRDATA),
        .HADDR(fp_HADDR), .HTRANS(fp_HTRANS), .HSIZE(fp_HSIZE), .HWRITE(fp_HWRITE), .HWDATA(fp_HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        w1;
        logic [31:0] d1;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_write;
        logic [31:0] e_wdata;
        logic        e_r0;
        logic        e_r1;
    } vec_t;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(logic rst, logic [1:0] t0, logic [31:0] a0, logic [31:0] d0,
                                logic [1:0] t1, logic [31:0] a1, logic w1, logic [31:0] d1,
                                logic [1:0] et, logic [31:0] ea, logic ew, logic [31:0] ed,
                                logic r0, logic r1);
        vec_t v;
        v.rst = rst; v.t0 = t0; v.a0 = a0; v.d0 = d0; v.t1 = t1; v.a1 = a1; v.w1 = w1; v.d1 = d1;
        v.e_trans = et; v.e_addr = ea; v.e_write = ew; v.e_wdata = ed; v.e_r0 = r0; v.e_r1 = r1;
        return v;
    endfunction

    task automatic drive(logic [1:0] t0, logic [31:0] a0, logic [31:0] d0,
                         logic [1:0] t1, logic [31:0] a1, logic w1, logic [31:0] d1, logic rdy);
        M0_HTRANS = t0; M0_HADDR = a0; M0_HWDATA = d0; M0_HWRITE = 1'b0;
        M1_HTRANS = t1; M1_HADDR = a1; M1_HWRITE = w1; M1_HWDATA = d1;
        HREADY = rdy;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    localparam logic [1:0] I = 2'b00, N = 2'b10;
    vec_t tbl[13];

    initial begin
        // After reset: idle check, T2 (contention after reset), T1 (lone read),
        // T3 (pending buffer), T6 (reset with a pend and an M1 data phase).
        tbl[0]  = mk(0, I, 0, 0,                  I, 0, 0, 0,                    I, 32'h0,         0, 32'h0,         1, 1);
        tbl[1]  = mk(0, N, 32'h2000_0000, 0,      N, 32'h2000_0040, 1, 0,        N, 32'h2000_0000, 0, 32'h0,         1, 0);
        tbl[2]  = mk(0, I, 0, 0,                  N, 32'h2000_0040, 1, 0,        N, 32'h2000_0040, 1, 32'h0,         1, 1);
        tbl[3]  = mk(0, N, 32'h10, 0,             I, 0, 0, 32'hCAFE_0001,        N, 32'h10,        0, 32'hCAFE_0001, 1, 1);
        tbl[4]  = mk(0, I, 0, 32'h1111_1111,      I, 0, 0, 0,                    I, 32'h0,         0, 32'h1111_1111, 1, 1);
        tbl[5]  = mk(0, N, 32'h2000_0000, 0,      I, 0, 0, 0,                    N, 32'h2000_0000, 0, 32'h0,         1, 1);
        tbl[6]  = mk(0, N, 32'h2000_0004, 0,      N, 32'h2000_0040, 1, 0,        N, 32'h2000_0040, 1, 32'h0,         1, 1);
        tbl[7]  = mk(0, I, 0, 0,                  I, 0, 0, 32'hA5A5_A5A5,        N, 32'h2000_0004, 0, 32'hA5A5_A5A5, 0, 1);
        tbl[8]  = mk(0, I, 0, 32'h2222_2222,      I, 0, 0, 0,                    I, 32'h0,         0, 32'h2222_2222, 1, 1);
        tbl[9]  = tbl[5];
        tbl[10] = tbl[6];
        tbl[11] = mk(1, I, 0, 0,                  I, 0, 0, 32'hA5A5_A5A5,        N, 32'h2000_0004, 0, 32'hA5A5_A5A5, 0, 1);
        tbl[12] = mk(0, I, 0, 0,                  I, 0, 0, 32'hA5A5_A5A5,        I, 32'h0,         0, 32'h0,         1, 1);

        HRESET = 1'b1;
        repeat (2) next_cycle();
        HRESET = 1'b0;

        for (int r = 0; r < 13; r++) begin
            HRESET = tbl[r].rst;
            drive(tbl[r].t0, tbl[r].a0, tbl[r].d0, tbl[r].t1, tbl[r].a1, tbl[r].w1, tbl[r].d1, 1'b1);
            HRDATA = 32'hD000_0000 + 32'(r);
            @(negedge HCLK);
            check($sformatf("row%0d HTRANS", r), 32'(HTRANS), 32'(tbl[r].e_trans));
            check($sformatf("row%0d HADDR", r), HADDR, tbl[r].e_addr);
            check($sformatf("row%0d HWRITE", r), 32'(HWRITE), 32'(tbl[r].e_write));
            check($sformatf("row%0d HWDATA", r), HWDATA, tbl[r].e_wdata);
            check($sformatf("row%0d M0_HREADY", r), 32'(M0_HREADY), 32'(tbl[r].e_r0));
            check($sformatf("row%0d M1_HREADY", r), 32'(M1_HREADY), 32'(tbl[r].e_r1));
            check($sformatf("row%0d M0_HRDATA", r), M0_HRDATA, 32'hD000_0000 + 32'(r));
            check($sformatf("row%0d M1_HRDATA", r), M1_HRDATA, 32'hD000_0000 + 32'(r));
            next_cycle();
        end
        HRESET = 1'b0;

        // T4: M1 write with two wait states while M0 requests.
        drive(I, 0, 0, N, 32'h4000_0000, 1, 0, 1'b1);
        @(negedge HCLK);
        check("t4 m1 HADDR", HADDR, 32'h4000_0000);
        check("t4 m1 HWRITE", 32'(HWRITE), 32'd1);
        check("t4 m1 HSIZE", 32'(HSIZE), 32'd0);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(N, 32'h100, 0, I, 0, 0, 32'hDEAD_BEEF, (c == 2));
            @(negedge HCLK);
            check($sformatf("t4 c%0d HADDR", c), HADDR, 32'h100);
            check($sformatf("t4 c%0d HTRANS", c), 32'(HTRANS), 32'(N));
            check($sformatf("t4 c%0d HSIZE", c), 32'(HSIZE), 32'd2);
            check($sformatf("t4 c%0d HWDATA", c), HWDATA, 32'hDEAD_BEEF);
            check($sformatf("t4 c%0d M0_HREADY", c), 32'(M0_HREADY), (c == 2) ? 32'd1 : 32'd0);
            check($sformatf("t4 c%0d M1_HREADY", c), 32'(M1_HREADY), (c == 2) ? 32'd1 : 32'd0);
            next_cycle();
        end
        drive(I, 0, 32'h3333_3333, I, 0, 0, 0, 1'b1);
        @(negedge HCLK);
        check("t4 m0 data HWDATA", HWDATA, 32'h3333_3333);
        check("t4 m0 data M0_HREADY", 32'(M0_HREADY), 32'd1);
        next_cycle();

        // T5: fixed priority, both masters request continuously.
        HRESET = 1'b1;
        drive(I, 0, 0, I, 0, 0, 0, 1'b1);
        next_cycle();
        HRESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(N, 32'h6000_0000 + 32'(4 * k), 0, N, 32'h7000_0000, 0, 0, 1'b1);
            @(negedge HCLK);
            check($sformatf("t5 k%0d fp HADDR", k), fp_HADDR, 32'h6000_0000 + 32'(4 * k));
            check($sformatf("t5 k%0d fp M1_HREADY", k), 32'(fp_M1_HREADY), 32'd0);
            check($sformatf("t5 k%0d fp M0_HREADY", k), 32'(fp_M0_HREADY), 32'd1);
            next_cycle();
        end
        drive(I, 0, 0, N, 32'h7000_0000, 0, 0, 1'b1);
        @(negedge HCLK);
        check("t5 m1 served fp HADDR", fp_HADDR, 32'h7000_0000);
        check("t5 m1 served fp M1_HREADY", 32'(fp_M1_HREADY), 32'd1);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
